// File: rtl/aes_pkg.sv
// Shared AES constants: S-box table, datapath widths, Rcon endpoints and the key-schedule state encoding.
// The EXPAND state exists only when AES_INV_KEY_FWD_EN is defined.
package aes_pkg;

  localparam int KEY_W   = 128;
  localparam int ROUND_W = 4;
  localparam int STATE_W = 2;

  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;
  localparam logic [7:0] RCON_WRAP  = 8'h1b;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
`ifdef AES_INV_KEY_FWD_EN
    ST_EXPAND = 2'd2,
`endif
    ST_RUN    = 2'd1
  } state_t;

  // Element 0 sits in the most significant byte, so SBOX[x] is S(x).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Walks the round constants backwards; 0x1b is the one value whose predecessor wrapped.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return (b == RCON_WRAP) ? 8'h80 : (b >> 1);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: takes K10 and streams round keys K10..K0 with valid/ready.
// Build option AES_INV_KEY_FWD_EN: accept K0 instead and expand forward to K10 first.
module aes_inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               IN_valid,
  input  logic [KEY_W-1:0]   IN_key,
  output logic               IN_ready,
  output logic               OUT_valid,
  input  logic               OUT_ready,
  output logic [KEY_W-1:0]   OUT_key,
  output logic [ROUND_W-1:0] OUT_round,
  output logic               OUT_last
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

  state_t             r_state;
  logic [KEY_W-1:0]   r_key;
  logic [ROUND_W-1:0] r_round;
  logic [7:0]         r_rcon;

  logic [31:0] w_a, w_b, w_c, w_d;
  logic [31:0] w_inv_a, w_inv_b, w_inv_c, w_inv_d;
  logic [31:0] w_sub_in, w_rot, w_sub;

  assign {w_a, w_b, w_c, w_d} = r_key;

  assign w_inv_d = w_d ^ w_c;
  assign w_inv_c = w_c ^ w_b;
  assign w_inv_b = w_b ^ w_a;

`ifdef AES_INV_KEY_FWD_EN
  logic [31:0] w_fwd_a, w_fwd_b, w_fwd_c, w_fwd_d;

  // One SubWord serves both directions: forward uses the old last word, inverse the recovered one.
  assign w_sub_in = (r_state == ST_EXPAND) ? w_d : w_inv_d;
  assign w_fwd_a  = w_a ^ w_sub ^ {r_rcon, 24'h0};
  assign w_fwd_b  = w_b ^ w_fwd_a;
  assign w_fwd_c  = w_c ^ w_fwd_b;
  assign w_fwd_d  = w_d ^ w_fwd_c;
`else
  assign w_sub_in = w_inv_d;
`endif

  assign w_rot   = {w_sub_in[23:0], w_sub_in[31:24]};
  assign w_inv_a = w_a ^ w_sub ^ {r_rcon, 24'h0};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*gi +: 8]),
      .o_byte (w_sub[8*gi +: 8])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_rcon  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (IN_valid) begin
            r_key <= IN_key;
`ifdef AES_INV_KEY_FWD_EN
            r_round <= '0;
            r_rcon  <= RCON_FIRST;
            r_state <= ST_EXPAND;
`else
            r_round <= LAST_ROUND;
            r_rcon  <= RCON_LAST;
            r_state <= ST_RUN;
`endif
          end
        end
`ifdef AES_INV_KEY_FWD_EN
        ST_EXPAND: begin
          // r_round counts completed forward steps until K10 is in r_key.
          r_key <= {w_fwd_a, w_fwd_b, w_fwd_c, w_fwd_d};
          if (r_round == LAST_ROUND - ROUND_W'(1)) begin
            r_round <= LAST_ROUND;
            r_rcon  <= RCON_LAST;
            r_state <= ST_RUN;
          end else begin
            r_round <= r_round + ROUND_W'(1);
            r_rcon  <= xtime(r_rcon);
          end
        end
`endif
        ST_RUN: begin
          if (OUT_ready) begin
            if (r_round == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_key   <= {w_inv_a, w_inv_b, w_inv_c, w_inv_d};
              r_round <= r_round - ROUND_W'(1);
              r_rcon  <= inv_xtime(r_rcon);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign IN_ready  = (r_state == ST_IDLE);
  assign OUT_valid = (r_state == ST_RUN);
  assign OUT_key   = r_key;
  assign OUT_round = r_round;
  assign OUT_last  = OUT_valid && (r_round == '0);

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: random K0 values are expanded forward by a FIPS-197 style model,
// K10 is fed in, and every streamed round key is checked against the model.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         IN_valid;
  logic [127:0] IN_key;
  logic         IN_ready;
  logic         OUT_valid;
  logic         OUT_ready;
  logic [127:0] OUT_key;
  logic [3:0]   OUT_round;
  logic         OUT_last;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sb  [256];
  logic [127:0] rk  [11];
  logic [127:0] obs [11];

  aes_inv_key_schedule #(.NR(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .IN_valid  (IN_valid),
    .IN_key    (IN_key),
    .IN_ready  (IN_ready),
    .OUT_valid (OUT_valid),
    .OUT_ready (OUT_ready),
    .OUT_key   (OUT_key),
    .OUT_round (OUT_round),
    .OUT_last  (OUT_last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic [7:0] a = x;
    logic [7:0] b = y;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // S-box derived from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called and returns on a falling edge. stall_round/abort_round of -1 disable those events.
  task automatic run_request(input logic [127:0] k0, input int stall_round, input int abort_round,
                             input bit hold_valid);
    expand(k0);
    check("idle_in_ready", IN_ready, 1);
    IN_valid = 1'b1;
    IN_key   = rk[10];
    @(negedge clk);
    if (hold_valid) IN_key = rand128();
    else            IN_valid = 1'b0;
    for (int r = 10; r >= 0; r--) begin
      check($sformatf("valid_r%0d", r), OUT_valid, 1);
      check($sformatf("round_r%0d", r), OUT_round, r);
      check($sformatf("key_r%0d", r), OUT_key, rk[r]);
      check($sformatf("last_r%0d", r), OUT_last, (r == 0));
      check($sformatf("busy_r%0d", r), IN_ready, 0);
      obs[r] = OUT_key;
      if (r == abort_round) begin
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", OUT_valid, 0);
        check("rst_async_ready", IN_ready, 1);
        check("rst_async_key", OUT_key, 0);
        check("rst_async_round", OUT_round, 0);
        check("rst_async_last", OUT_last, 0);
        IN_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("txn abort k0=%h at round %0d", k0, r);
        return;
      end
      if (r == stall_round) begin
        OUT_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check($sformatf("stall_valid_r%0d", r), OUT_valid, 1);
          check($sformatf("stall_round_r%0d", r), OUT_round, r);
          check($sformatf("stall_key_r%0d", r), OUT_key, rk[r]);
        end
        OUT_ready = 1'b1;
      end
      if (r == 0) IN_valid = 1'b0;
      @(negedge clk);
    end
    check("done_in_ready", IN_ready, 1);
    check("done_out_valid", OUT_valid, 0);
    $display("txn k0=%h k10=%h stall=%0d hold=%0d", k0, rk[10], stall_round, hold_valid);
  endtask

  initial begin
    logic [127:0] fips_k0;
    fips_k0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    IN_valid  = 1'b0;
    IN_key    = '0;
    OUT_ready = 1'b1;
    reset     = 1'b1;
    build_sbox();
    repeat (2) @(negedge clk);
    check("reset_in_ready", IN_ready, 1);
    check("reset_out_valid", OUT_valid, 0);
    check("reset_out_last", OUT_last, 0);
    check("reset_out_round", OUT_round, 0);
    check("reset_out_key", OUT_key, 0);
    reset = 1'b0;
    @(negedge clk);

    run_request(fips_k0, -1, -1, 1'b0);
    check("fips_r10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_r9", obs[9], 128'hac7766f319fadc2128d12941575c006e);
    check("fips_r1", obs[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r0", obs[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    run_request(fips_k0, 7, -1, 1'b0);
    run_request(rand128(), -1, 4, 1'b0);
    run_request(rand128(), -1, -1, 1'b0);
    run_request(fips_k0, -1, -1, 1'b1);
    check("hold_r0", obs[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    for (int i = 0; i < 4; i++)
      run_request(rand128(), int'($urandom_range(0, 10)), -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_schedule.md
AES_INV_KEY_SCHEDULE -- requirements
Module: aes_inv_key_schedule

Interface
REQ-001 Parameter NR, default 10, number of AES-128 rounds; only 10 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 IN_valid  input  1  key request; high means IN_key is valid.
REQ-005 IN_key  input  128  last-round key K10; bits [127:96] are word w40, MSB is byte 0.
REQ-006 IN_ready  output  1  high when a request can be accepted.
REQ-007 OUT_valid  output  1  high means OUT_key/OUT_round are valid.
REQ-008 OUT_ready  input  1  consumer accepts the current round key.
REQ-009 OUT_key  output  128  round key K[OUT_round], same byte order as IN_key.
REQ-010 OUT_round  output  4  round index of OUT_key, 10 down to 0.
REQ-011 OUT_last  output  1  high with OUT_valid when OUT_round==0.

Function
REQ-012 States SHALL be IDLE and RUN, plus EXPAND only when AES_INV_KEY_FWD_EN is defined.
REQ-013 IDLE: IN_ready=1, OUT_valid=0; IN_valid&&IN_ready loads key_reg<=IN_key, round<=10, rcon<=8'h36, next state RUN.
REQ-014 RUN: IN_ready=0, OUT_valid=1, OUT_key=key_reg, OUT_round=round; first OUT_valid is the cycle after acceptance (latency 1).
REQ-015 RUN with OUT_ready=0 SHALL hold key_reg, round and rcon unchanged (no output change under backpressure).
REQ-016 RUN with OUT_ready=1 and round!=0: key_reg<=prev(key_reg), round<=round-1, rcon<=inv_xtime(rcon).
REQ-017 RUN with OUT_ready=1 and round==0: next state IDLE; exactly 11 keys are emitted per request.
REQ-018 prev(): with current words a,b,c,d: d'=d^c, c'=c^b, b'=b^a, a'=a^SubWord(RotWord(d'))^{rcon,24'h0}; all four computed in one cycle.
REQ-019 inv_xtime: rcon==8'h1b gives 8'h80, else rcon>>1; sequence 36,1b,80,40,20,10,08,04,02,01.
REQ-020 IN_valid while not in IDLE SHALL be ignored (IN_ready=0); no request is queued.
REQ-021 Back-to-back requests: IN_ready rises the cycle after the round-0 handshake.

Reset
REQ-022 reset SHALL force IDLE, IN_ready=1, OUT_valid=0, OUT_last=0, OUT_round=0, OUT_key=0, key_reg=0, rcon=0, from any state including mid-sequence.
REQ-023 The first request after reset deassertion SHALL behave as REQ-013.

Configuration
REQ-024 Macro AES_INV_KEY_FWD_EN: when defined, IN_key is cipher key K0; on acceptance the block enters EXPAND.
REQ-025 EXPAND runs forward expansion for 10 cycles (rcon 01..36, IN_ready=0, OUT_valid=0), then enters RUN with K10; first OUT_valid is 11 cycles after acceptance.
REQ-026 With the macro defined, one SubWord instance is muxed between the forward and inverse datapaths.
REQ-027 Without the macro, EXPAND logic SHALL be absent and IN_key is K10.

Structure
REQ-028 Shared package aes_pkg holds the S-box table, the state/round/key widths, the Rcon constants and the state enum encoding.
REQ-029 Sub-module aes_sbox (8-bit combinational S-box) is instantiated 4 times for SubWord.

Verification
REQ-030 Request with K10=d014f9a8c9ee2589e13f0cc8b6630ca6, OUT_ready=1 -> cycle+1: round 10 key equal to K10; next cycle: round 9 = ac7766f319fadc2128d12941575c006e.
REQ-031 Same request, full run -> round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e151628aed2a6abf7158809cf4f3c with OUT_last=1; then IDLE.
REQ-032 OUT_ready low for 5 cycles at round 7 -> OUT_key and OUT_round are stable throughout; sequence resumes correctly.
REQ-033 reset pulse at round 4 -> OUT_valid=0 asynchronously, IN_ready=1 after release; new request restarts at round 10.
REQ-034 IN_valid held high during RUN with a different key -> ignored; sequence from REQ-031 is unaffected.
REQ-035 With AES_INV_KEY_FWD_EN: IN_key=2b7e151628aed2a6abf7158809cf4f3c -> OUT_valid 11 cycles later with K10=d014f9a8c9ee2589e13f0cc8b6630ca6.
